// File: rtl/bram_port_initiator.sv
// Requester-side front end for a true dual-port BRAM. Two valid/ready
// request channels are mapped onto BRAM ports 0/1. Same-address hazards
// are serialised round-robin, and read data is returned on per-channel
// response strobes after the BRAM's read latency.

// One request channel: registers the BRAM port signals for one cycle per
// handshake and tracks in-flight reads down a latency-matched valid pipe.
module bram_port_chan #(
    parameter int DWIDTH    = 8,
    parameter int ADDR_W    = 8,
    parameter int READ_SYNC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hs,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [DWIDTH-1:0] data_out,
    output logic              port_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] addr_in,
    output logic [DWIDTH-1:0] data_in,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata
);
    // Stage k is set k edges after a read handshake; the last stage marks the
    // cycle in which data_out carries that read's word.
    localparam int STAGES = READ_SYNC;

    logic [STAGES:0] vld_pipe;

    // Issue registers, read-latency pipe and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_en   <= 1'b0;
            wr_en     <= 1'b0;
            addr_in   <= '0;
            data_in   <= '0;
            vld_pipe  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            port_en <= hs;
            wr_en   <= hs & wr;
            // Address/data hold their last values between requests.
            if (hs) begin
                addr_in <= addr;
                data_in <= wdata;
            end
            vld_pipe[0] <= hs & ~wr;
            for (int i = 1; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
            rsp_valid <= vld_pipe[STAGES];
            if (vld_pipe[STAGES]) begin
                rsp_rdata <= data_out;
            end
        end
    end
endmodule

module bram_port_initiator #(
    parameter int DWIDTH    = 8,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 8,
    parameter int READ_SYNC = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic              req_wr_0,
    input  logic              req_wr_1,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DWIDTH-1:0] req_wdata_0,
    input  logic [DWIDTH-1:0] req_wdata_1,
    output logic              rsp_valid_0,
    output logic              rsp_valid_1,
    output logic [DWIDTH-1:0] rsp_rdata_0,
    output logic [DWIDTH-1:0] rsp_rdata_1,
    output logic              clk_en,
    output logic              singleportmode,
    output logic              port_en_0,
    output logic              wr_en_0,
    output logic [ADDR_W-1:0] addr_in_0,
    output logic [DWIDTH-1:0] data_in_0,
    input  logic [DWIDTH-1:0] data_out_0,
    output logic              port_en_1,
    output logic              wr_en_1,
    output logic [ADDR_W-1:0] addr_in_1,
    output logic [DWIDTH-1:0] data_in_1,
    input  logic [DWIDTH-1:0] data_out_1,
    input  logic              collision_flag,
    output logic              err_collision,
    output logic [CNT_W-1:0]  conflict_cnt
);
    // The address must be able to reach every BRAM word.
    if (DEPTH > (1 << ADDR_W)) begin : g_depth_chk
        $error("bram_port_initiator: DEPTH exceeds 2**ADDR_W");
    end

    logic                         ptr;      // channel that wins the next conflict
    logic                         conflict;
    logic [1:0]                   hs, wr, port_en, wr_en, rsp_valid;
    logic [1:0][ADDR_W-1:0]       addr, addr_in;
    logic [1:0][DWIDTH-1:0]       wdata, data_out, data_in, rsp_rdata;

    // A write on either side to a shared address is a hazard; read/read is not.
    assign conflict = req_valid_0 & req_valid_1 & (req_addr_0 == req_addr_1)
                    & (req_wr_0 | req_wr_1);

    assign req_ready_0 = ~rst & (~conflict | ~ptr);
    assign req_ready_1 = ~rst & (~conflict |  ptr);

    assign hs       = {req_valid_1 & req_ready_1, req_valid_0 & req_ready_0};
    assign wr       = {req_wr_1, req_wr_0};
    assign addr     = {req_addr_1, req_addr_0};
    assign wdata    = {req_wdata_1, req_wdata_0};
    assign data_out = {data_out_1, data_out_0};

    for (genvar c = 0; c < 2; c++) begin : g_chan
        bram_port_chan #(
            .DWIDTH   (DWIDTH),
            .ADDR_W   (ADDR_W),
            .READ_SYNC(READ_SYNC)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .hs       (hs[c]),
            .wr       (wr[c]),
            .addr     (addr[c]),
            .wdata    (wdata[c]),
            .data_out (data_out[c]),
            .port_en  (port_en[c]),
            .wr_en    (wr_en[c]),
            .addr_in  (addr_in[c]),
            .data_in  (data_in[c]),
            .rsp_valid(rsp_valid[c]),
            .rsp_rdata(rsp_rdata[c])
        );
    end

    assign port_en_0      = port_en[0];
    assign wr_en_0        = wr_en[0];
    assign addr_in_0      = addr_in[0];
    assign data_in_0      = data_in[0];
    assign port_en_1      = port_en[1];
    assign wr_en_1        = wr_en[1];
    assign addr_in_1      = addr_in[1];
    assign data_in_1      = data_in[1];
    assign rsp_valid_0    = rsp_valid[0];
    assign rsp_valid_1    = rsp_valid[1];
    assign rsp_rdata_0    = rsp_rdata[0];
    assign rsp_rdata_1    = rsp_rdata[1];
    assign singleportmode = 1'b0;

    // Clock enable, round-robin pointer, stall counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_en        <= 1'b0;
            ptr           <= 1'b0;
            conflict_cnt  <= '0;
            err_collision <= 1'b0;
        end else begin
            clk_en <= 1'b1;
            if (conflict) begin
                ptr <= ~ptr;
                if (conflict_cnt != {CNT_W{1'b1}}) begin
                    conflict_cnt <= conflict_cnt + 1'b1;
                end
            end
            if (collision_flag) begin
                err_collision <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bram_port_initiator.sv
// Drives two initiators (READ_SYNC=0 and READ_SYNC=1) with identical request
// streams, each attached to its own behavioural BRAM, and checks them against
// a transaction-level model of the request/response rules.
module tb_bram_port_initiator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coll = 1'b0;
    logic       v [2];
    logic       w [2];
    logic [7:0] a [2];
    logic [7:0] d [2];

    logic        rdy0 [2], rdy1 [2], rv0 [2], rv1 [2], cke [2], spm [2];
    logic        pe0 [2], we0 [2], pe1 [2], we1 [2], err [2];
    logic [7:0]  rd0 [2], rd1 [2], ai0 [2], di0 [2], do0 [2], ai1 [2], di1 [2], do1 [2];
    logic [15:0] cnt [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // reference model state
    logic [7:0] m_mem [256];
    bit         m_ptr, m_clken, m_err;
    int         m_cnt;
    bit         exp_v [4][2048];
    logic [7:0] exp_d [4][2048];
    logic [7:0] m_rdata [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bram_port_initiator #(.READ_SYNC(g)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid_0(v[0]), .req_valid_1(v[1]),
            .req_ready_0(rdy0[g]), .req_ready_1(rdy1[g]),
            .req_wr_0(w[0]), .req_wr_1(w[1]),
            .req_addr_0(a[0]), .req_addr_1(a[1]),
            .req_wdata_0(d[0]), .req_wdata_1(d[1]),
            .rsp_valid_0(rv0[g]), .rsp_valid_1(rv1[g]),
            .rsp_rdata_0(rd0[g]), .rsp_rdata_1(rd1[g]),
            .clk_en(cke[g]), .singleportmode(spm[g]),
            .port_en_0(pe0[g]), .wr_en_0(we0[g]), .addr_in_0(ai0[g]),
            .data_in_0(di0[g]), .data_out_0(do0[g]),
            .port_en_1(pe1[g]), .wr_en_1(we1[g]), .addr_in_1(ai1[g]),
            .data_in_1(di1[g]), .data_out_1(do1[g]),
            .collision_flag(coll), .err_collision(err[g]), .conflict_cnt(cnt[g])
        );

        // behavioural true dual-port BRAM
        logic [7:0] mem [256];
        logic [7:0] q0, q1;
        initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        always @(posedge clk) begin
            if (cke[g]) begin
                if (pe0[g] && we0[g]) mem[ai0[g]] <= di0[g];
                if (pe1[g] && we1[g]) mem[ai1[g]] <= di1[g];
                if (pe0[g]) q0 <= mem[ai0[g]];
                if (pe1[g]) q1 <= mem[ai1[g]];
            end
        end
        assign do0[g] = (g == 1) ? q0 : mem[ai0[g]];
        assign do1[g] = (g == 1) ? q1 : mem[ai1[g]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic do_cycle();
        bit conf;
        bit g [2];
        if (rst) begin
            m_ptr = 0; m_cnt = 0; m_clken = 0; m_err = 0;
            for (int k = 0; k < 4; k++) begin
                m_rdata[k] = 8'h00;
                for (int t = cyc + 1; t <= cyc + 3; t++) exp_v[k][t] = 0;
            end
        end
        #1;
        conf = v[0] && v[1] && (a[0] == a[1]) && (w[0] || w[1]);
        for (int i = 0; i < 2; i++) begin
            chk("ready0", 32'(rdy0[i]), 32'(!rst && (!conf || !m_ptr)));
            chk("ready1", 32'(rdy1[i]), 32'(!rst && (!conf || m_ptr)));
        end
        g[0] = !rst && v[0] && (!conf || !m_ptr);
        g[1] = !rst && v[1] && (!conf || m_ptr);
        @(posedge clk);
        cyc++;
        if (!rst) begin
            m_clken = 1;
            for (int c = 0; c < 2; c++)
                if (g[c] && !w[c])
                    for (int i = 0; i < 2; i++) begin
                        exp_v[i*2+c][cyc+1+i] = 1;
                        exp_d[i*2+c][cyc+1+i] = m_mem[a[c]];
                    end
            for (int c = 0; c < 2; c++)
                if (g[c] && w[c]) m_mem[a[c]] = d[c];
            if (conf) begin
                m_ptr = !m_ptr;
                if (m_cnt < 65535) m_cnt++;
            end
            if (coll) m_err = 1;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++)
                if (exp_v[i*2+c][cyc]) m_rdata[i*2+c] = exp_d[i*2+c][cyc];
            chk("rsp_valid0", 32'(rv0[i]), 32'(exp_v[i*2][cyc]));
            chk("rsp_valid1", 32'(rv1[i]), 32'(exp_v[i*2+1][cyc]));
            chk("rsp_rdata0", 32'(rd0[i]), 32'(m_rdata[i*2]));
            chk("rsp_rdata1", 32'(rd1[i]), 32'(m_rdata[i*2+1]));
            chk("port_en0", 32'(pe0[i]), 32'(g[0]));
            chk("port_en1", 32'(pe1[i]), 32'(g[1]));
            if (g[0]) chk("addr_in0", 32'(ai0[i]), 32'(a[0]));
            if (g[1]) chk("addr_in1", 32'(ai1[i]), 32'(a[1]));
            chk("clk_en", 32'(cke[i]), 32'(m_clken));
            chk("conflict_cnt", 32'(cnt[i]), 32'(m_cnt));
            chk("err_collision", 32'(err[i]), 32'(m_err));
        end
        for (int c = 0; c < 2; c++) if (g[c]) v[c] = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((v[0] || v[1]) && n < 8) begin
            do_cycle();
            n++;
        end
        chk("drain_timeout", 32'(v[0] || v[1]), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle();
    endtask

    task automatic req(input int c, input logic wr, input logic [7:0] ad, input logic [7:0] dat);
        v[c] = 1; w[c] = wr; a[c] = ad; d[c] = dat;
    endtask

    task automatic do_reset();
        v[0] = 0; v[1] = 0;
        rst = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_port_en0", 32'(pe0[i]), 32'd0);
            chk("rst_port_en1", 32'(pe1[i]), 32'd0);
            chk("rst_rsp_valid", 32'(rv0[i] | rv1[i]), 32'd0);
            chk("rst_addr", 32'({ai0[i], ai1[i]}), 32'd0);
            chk("rst_data", 32'({di0[i], di1[i]}), 32'd0);
            chk("rst_rdata", 32'({rd0[i], rd1[i]}), 32'd0);
            chk("rst_clk_en", 32'(cke[i]), 32'd0);
            chk("rst_err", 32'(err[i]), 32'd0);
            chk("rst_cnt", 32'(cnt[i]), 32'd0);
            chk("rst_ready", 32'({rdy0[i], rdy1[i]}), 32'd0);
        end
        idle(2);
        rst = 0;
        idle(1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h5A;
        v[0] = 0; v[1] = 0; w[0] = 0; w[1] = 0;
        a[0] = 0; a[1] = 0; d[0] = 0; d[1] = 0;
        @(negedge clk);
        chk("singleportmode", 32'(spm[0] | spm[1]), 32'd0);
        do_reset();

        // write then read on the other channel; then back-to-back reads
        req(0, 1, 8'h10, 8'hD0); drain();
        req(1, 0, 8'h10, 8'h00); drain();
        idle(3);
        req(0, 1, 8'h11, 8'h22); drain();
        req(1, 0, 8'h10, 8'h00); do_cycle();
        req(1, 0, 8'h11, 8'h00); do_cycle();
        idle(3);

        // write/read hazard on one address straight after reset
        do_reset();
        req(0, 1, 8'h10, 8'hF1); req(1, 0, 8'h10, 8'h00); drain();
        idle(3);
        chk("cnt_after_wr_rd", 32'(cnt[0]), 32'd1);

        // write/write hazard, read back, then the same hazard again
        req(0, 1, 8'h20, 8'hA5); req(1, 1, 8'h20, 8'h5A); drain();
        req(0, 0, 8'h20, 8'h00); drain();
        idle(3);
        req(0, 1, 8'h20, 8'h11); req(1, 1, 8'h20, 8'h22); drain();
        idle(1);

        // read/read on one address is never stalled
        req(0, 0, 8'h30, 8'h00); req(1, 0, 8'h30, 8'h00); do_cycle();
        chk("rd_rd_no_stall", 32'(v[0] || v[1]), 32'd0);
        idle(3);

        // reset with reads in flight, then a collision report
        req(0, 0, 8'h31, 8'h00); req(1, 0, 8'h32, 8'h00); do_cycle();
        do_reset();
        idle(3);
        coll = 1; do_cycle();
        coll = 0; idle(3);
        chk("err_sticky", 32'(err[1]), 32'd1);
        do_reset();

        // randomized traffic on a small address window to force hazards
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < 2; c++)
                if (!v[c] && $urandom_range(0, 3) != 0)
                    req(c, 1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 3)), 8'($urandom));
            do_cycle();
        end
        v[0] = 0; v[1] = 0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
